ep01_truth_table_scanner: RTL and testbench

Sequential stimulus/capture stage wrapped around a 4-input combinational function block: on a start pulse it drives all 16 combinations of `a`, `b`, `c`, `d` into the function stage, samples its `f` output for each combination, and assembles a 16-bit truth table. It sits directly upstream of the function stage, feeding its inputs, and consumes its output on the return path. It is used for on-board self-check of the EP1 combinational circuits.

---
 rtl/ep01_truth_table_scanner.sv | 132 +++++++++++++
 tb/tb_ep01_truth_table_scanner.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ep01_truth_table_scanner.sv
// rtl/ep01_truth_table_scanner.sv - drives all 16 {a,b,c,d} vectors into a function stage and captures its truth table
// Optional golden-table compare enabled by defining SCAN_COMPARE_EN.
module ep01_truth_table_scanner #(
    parameter int SETTLE = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        f,
    input  logic [15:0] expected,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic [4:0]  ones_count,
    output logic        mismatch,
    output logic [3:0]  first_bad
);

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    localparam logic [3:0] LAST = 4'(SETTLE - 1);

    state_t      state_q;
    logic [3:0]  idx_q;
    logic [3:0]  cnt_q;
    logic [15:0] table_q, table_d;
    logic [4:0]  ones_q, ones_d;
    logic        busy_q;
    logic        done_q;
    logic        sample;
    logic        last_sample;

    assign sample      = (state_q == DRIVE) && (cnt_q == LAST);
    assign last_sample = sample && (idx_q == 4'd15);

    always_comb begin
        table_d        = table_q;
        table_d[idx_q] = f;
        ones_d         = ones_q + {4'd0, f};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            table_q <= '0;
            ones_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= DRIVE;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        table_q <= '0;
                        ones_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (sample) begin
                        table_q <= table_d;
                        ones_q  <= ones_d;
                        cnt_q   <= '0;
                        // idx wraps 15 -> 0 on the final sample, leaving a..d at 0 in DONE/IDLE
                        idx_q   <= idx_q + 4'd1;
                        if (last_sample) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign {a, b, c, d} = idx_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign table_out    = table_q;
    assign ones_count   = ones_q;

`ifdef SCAN_COMPARE_EN
    logic [15:0] exp_q;
    logic        cmp_valid_q;
    logic [15:0] diff;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            exp_q       <= '0;
            cmp_valid_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            exp_q       <= expected;
            cmp_valid_q <= 1'b0;
        end else if (last_sample) begin
            cmp_valid_q <= 1'b1;
        end
    end

    assign diff     = table_q ^ exp_q;
    assign mismatch = cmp_valid_q && (|diff);

    always_comb begin
        first_bad = '0;
        for (int i = 15; i >= 0; i--) begin
            if (cmp_valid_q && diff[i]) first_bad = 4'(i);
        end
    end
`else
    logic unused_expected;
    assign unused_expected = ^expected;
    assign mismatch        = 1'b0;
    assign first_bad       = '0;
`endif

endmodule

// File: tb/tb_ep01_truth_table_scanner.sv
// tb/tb_ep01_truth_table_scanner.sv - directed self-checking bench for ep01_truth_table_scanner
module tb_ep01_truth_table_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        s2_start = 1'b0;
    logic        s2_f;
    logic [15:0] s2_expected = 16'h0000;
    logic        s2_a, s2_b, s2_c, s2_d, s2_busy, s2_done, s2_mismatch;
    logic [15:0] s2_table;
    logic [4:0]  s2_ones;
    logic [3:0]  s2_first_bad;

    logic        s1_start = 1'b0;
    logic        s1_a, s1_b, s1_c, s1_d, s1_busy, s1_done, s1_mismatch;
    logic [15:0] s1_table;
    logic [4:0]  s1_ones;
    logic [3:0]  s1_first_bad;

    int          f_mode = 0;
    int          checks = 0;
    int          errors = 0;
    int          n_done;
    int          j;
    int          busy_cycles;

    always #5 clk = ~clk;

    // Function stage under scan, selected by f_mode
    always_comb begin
        case (f_mode)
            0:       s2_f = s2_a ? (s2_b | s2_c) : (s2_c ? (s2_b | s2_d) : (s2_b & s2_d));
            1:       s2_f = s2_d;
            2:       s2_f = s2_a;
            default: s2_f = 1'b0;
        endcase
    end

    ep01_truth_table_scanner #(.SETTLE(2)) u_s2 (
        .clock(clk), .reset(rst), .start(s2_start), .f(s2_f), .expected(s2_expected),
        .a(s2_a), .b(s2_b), .c(s2_c), .d(s2_d), .busy(s2_busy), .done(s2_done),
        .table_out(s2_table), .ones_count(s2_ones), .mismatch(s2_mismatch), .first_bad(s2_first_bad)
    );

    ep01_truth_table_scanner #(.SETTLE(1)) u_s1 (
        .clock(clk), .reset(rst), .start(s1_start), .f(1'b1), .expected(16'hFFFF),
        .a(s1_a), .b(s1_b), .c(s1_c), .d(s1_d), .busy(s1_busy), .done(s1_done),
        .table_out(s1_table), .ones_count(s1_ones), .mismatch(s1_mismatch), .first_bad(s1_first_bad)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_s2_zero(input string tag);
        check({tag, "_abcd"}, {28'd0, s2_a, s2_b, s2_c, s2_d}, 32'd0);
        check({tag, "_busy_done"}, {30'd0, s2_busy, s2_done}, 32'd0);
        check({tag, "_table"}, {16'd0, s2_table}, 32'd0);
        check({tag, "_ones"}, {27'd0, s2_ones}, 32'd0);
        check({tag, "_cmp"}, {27'd0, s2_mismatch, s2_first_bad}, 32'd0);
    endtask

    // Pulse start on s2; j = negedges after the accept edge until done (0 = first negedge after accept)
    task automatic scan_s2(input bit extra_starts);
        s2_start = 1'b1;
        @(negedge clk);
        s2_start = 1'b0;
        check("s2_busy_after_start", {31'd0, s2_busy}, 32'd1);
        j = 0;
        while (!s2_done && j < 100) begin
            s2_start = extra_starts && (j == 5 || j == 20);
            @(negedge clk);
            j++;
        end
        s2_start = 1'b0;
        if (s2_done && extra_starts) begin
            s2_start = 1'b1;
            @(negedge clk);
            s2_start = 1'b0;
            check("s2_done_one_cycle", {31'd0, s2_done}, 32'd0);
        end
    endtask

    task automatic count_s2_done(input int cycles);
        n_done = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (s2_done) n_done++;
        end
    endtask

    initial begin
        // Reset state
        #3;
        check_s2_zero("reset");
        check("s1_reset_table", {16'd0, s1_table}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Spec function, SETTLE=2
        f_mode = 0;
        s2_expected = 16'hFCE8;
        scan_s2(1'b0);
        check("s2_latency", j, 32'd32);
        check("s2_table_fce8", {16'd0, s2_table}, 32'h0000FCE8);
        check("s2_ones_10", {27'd0, s2_ones}, 32'd10);
        check("s2_busy_in_done", {31'd0, s2_busy}, 32'd0);
        check("s2_abcd_wrapped", {28'd0, s2_a, s2_b, s2_c, s2_d}, 32'd0);
`ifdef SCAN_COMPARE_EN
        check("s2_mismatch_match", {31'd0, s2_mismatch}, 32'd0);
`else
        check("s2_mismatch_tied", {31'd0, s2_mismatch}, 32'd0);
`endif
        @(negedge clk);
        check("s2_done_cleared", {31'd0, s2_done}, 32'd0);
        check("s2_table_hold", {16'd0, s2_table}, 32'h0000FCE8);

        // Wrong golden table, with extra starts during DRIVE and DONE
        s2_expected = 16'hFCEC;
        scan_s2(1'b1);
        check("extra_latency", j, 32'd32);
        check("extra_table", {16'd0, s2_table}, 32'h0000FCE8);
`ifdef SCAN_COMPARE_EN
        check("s2_mismatch_bad", {31'd0, s2_mismatch}, 32'd1);
        check("s2_first_bad", {28'd0, s2_first_bad}, 32'd2);
`else
        check("s2_cmp_tied", {27'd0, s2_mismatch, s2_first_bad}, 32'd0);
`endif
        count_s2_done(40);
        check("extra_no_second_done", n_done, 32'd0);
        check("extra_idle_busy", {31'd0, s2_busy}, 32'd0);

        // Reset asserted during vector 7, between clock edges
        s2_expected = 16'hFCE8;
        s2_start = 1'b1;
        @(negedge clk);
        s2_start = 1'b0;
        j = 0;
        while ({s2_a, s2_b, s2_c, s2_d} != 4'd7 && j < 100) begin
            @(negedge clk);
            j++;
        end
        check("reach_vec7", {28'd0, s2_a, s2_b, s2_c, s2_d}, 32'd7);
        #2;
        rst = 1'b1;
        #1;
        check_s2_zero("midscan_reset");
        @(negedge clk);
        rst = 1'b0;
        count_s2_done(40);
        check("reset_no_done", n_done, 32'd0);
        scan_s2(1'b0);
        check("after_reset_latency", j, 32'd32);
        check("after_reset_table", {16'd0, s2_table}, 32'h0000FCE8);
`ifdef SCAN_COMPARE_EN
        check("after_reset_mismatch", {31'd0, s2_mismatch}, 32'd0);
`endif
        @(negedge clk);

        // Back-to-back: f = d then f = a
        f_mode = 1;
        scan_s2(1'b0);
        check("fd_table", {16'd0, s2_table}, 32'h0000AAAA);
        check("fd_ones", {27'd0, s2_ones}, 32'd8);
        @(negedge clk);
        f_mode = 2;
        s2_start = 1'b1;
        @(negedge clk);
        s2_start = 1'b0;
        check("restart_clears_table", {16'd0, s2_table}, 32'd0);
        check("restart_clears_ones", {27'd0, s2_ones}, 32'd0);
        j = 0;
        while (!s2_done && j < 100) begin
            @(negedge clk);
            j++;
        end
        check("fa_table", {16'd0, s2_table}, 32'h0000FF00);
        check("fa_ones", {27'd0, s2_ones}, 32'd8);

        // f tied to 1, SETTLE=1: one vector per cycle
        @(negedge clk);
        s1_start = 1'b1;
        @(negedge clk);
        s1_start = 1'b0;
        busy_cycles = 0;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("s1_vec%0d", k), {28'd0, s1_a, s1_b, s1_c, s1_d}, 32'(k));
            if (s1_busy) busy_cycles++;
            @(negedge clk);
        end
        check("s1_done", {31'd0, s1_done}, 32'd1);
        check("s1_busy_cycles", busy_cycles, 32'd16);
        check("s1_busy_low", {31'd0, s1_busy}, 32'd0);
        check("s1_table_ffff", {16'd0, s1_table}, 32'h0000FFFF);
        check("s1_ones_16", {27'd0, s1_ones}, 32'd16);
        check("s1_cmp_clear", {27'd0, s1_mismatch, s1_first_bad}, 32'd0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
